// File: rtl/rtc_tick_gen.sv
// rtc_tick_gen: configurable fast/second/key-period tick generator.
// Ports: sys_clk, sys_rst (sync, active-high), en, resync in;
//   clk_fast, tick_fast, clk_key, key_tick, sec_tick, secs_left out.
module rtc_tick_gen #(
  parameter int SYS_CLK_HZ       = 1000000,
  parameter int FAST_HZ          = 500,
  parameter int KEYCHANGE_PERIOD = 5,
  parameter int CNT_W            = 32,
  parameter int SEC_W            = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             resync,
  output logic             clk_fast,
  output logic             tick_fast,
  output logic             clk_key,
  output logic             key_tick,
  output logic             sec_tick,
  output logic [SEC_W-1:0] secs_left
);

  localparam longint SYS_L    = longint'(SYS_CLK_HZ);
  localparam longint FAST_DIV = SYS_L / longint'(FAST_HZ);
  localparam longint KEY_DIV  = longint'(KEYCHANGE_PERIOD) * SYS_L;

  if ((SYS_CLK_HZ % (2 * FAST_HZ)) != 0 ||
      (SYS_CLK_HZ % 2) != 0 ||
      KEYCHANGE_PERIOD < 1 ||
      KEY_DIV >= (longint'(1) << CNT_W) ||
      longint'(KEYCHANGE_PERIOD) >= (longint'(1) << SEC_W)) begin : g_bad_params
    $error("rtc_tick_gen: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] FAST_MAX  = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_HALF = CNT_W'(FAST_DIV / 2);
  localparam logic [CNT_W-1:0] SEC_MAX   = CNT_W'(SYS_L - 1);
  localparam logic [CNT_W-1:0] KEY_MAX   = CNT_W'(KEY_DIV - 1);
  localparam logic [CNT_W-1:0] KEY_HALF  = CNT_W'(KEY_DIV / 2);
  localparam logic [SEC_W-1:0] SECS_INIT = SEC_W'(KEYCHANGE_PERIOD);

  logic [CNT_W-1:0] fast_cnt;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] key_cnt;

  logic             fast_wrap;
  logic             sec_wrap;
  logic             key_wrap;
  logic [CNT_W-1:0] fast_nxt;
  logic [CNT_W-1:0] sec_nxt;
  logic [CNT_W-1:0] key_nxt;

  // Wrap flags describe the edge about to happen: the counter returns
  // to 0, which is exactly when the strobe for that period is due.
  always_comb begin
    fast_wrap = (fast_cnt == FAST_MAX);
    sec_wrap  = (sec_cnt == SEC_MAX);
    key_wrap  = (key_cnt == KEY_MAX);
    fast_nxt  = fast_wrap ? '0 : fast_cnt + CNT_W'(1);
    sec_nxt   = sec_wrap ? '0 : sec_cnt + CNT_W'(1);
    key_nxt   = key_wrap ? '0 : key_cnt + CNT_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || resync) begin
      fast_cnt  <= '0;
      sec_cnt   <= '0;
      key_cnt   <= '0;
      clk_fast  <= 1'b0;
      tick_fast <= 1'b0;
      clk_key   <= 1'b0;
      key_tick  <= 1'b0;
      sec_tick  <= 1'b0;
      secs_left <= SECS_INIT;
    end else if (en) begin
      fast_cnt  <= fast_nxt;
      sec_cnt   <= sec_nxt;
      key_cnt   <= key_nxt;
      // Levels are decoded from the post-edge count so they line up
      // with the strobes without an extra pipeline stage.
      clk_fast  <= (fast_nxt >= FAST_HALF);
      clk_key   <= (key_nxt >= KEY_HALF);
      tick_fast <= fast_wrap;
      sec_tick  <= sec_wrap;
      key_tick  <= key_wrap;
      // A key wrap always lands on a second wrap; reload takes priority.
      if (key_wrap)
        secs_left <= SECS_INIT;
      else if (sec_wrap)
        secs_left <= secs_left - SEC_W'(1);
    end else begin
      tick_fast <= 1'b0;
      sec_tick  <= 1'b0;
      key_tick  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtc_tick_gen.sv
// tb_rtc_tick_gen: directed bench for rtc_tick_gen with a 20 Hz clock,
// 5 Hz fast tick and 3 s key period (FAST_DIV=4, KEY_DIV=60).
module tb_rtc_tick_gen;

  localparam int SEC_W = 8;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             en      = 1'b0;
  logic             resync  = 1'b0;
  logic             clk_fast;
  logic             tick_fast;
  logic             clk_key;
  logic             key_tick;
  logic             sec_tick;
  logic [SEC_W-1:0] secs_left;

  int passed = 0;
  int total  = 0;
  int n      = 0;
  bit counted = 0;
  int n_tf, n_st, n_kt;

  rtc_tick_gen #(
    .SYS_CLK_HZ      (20),
    .FAST_HZ         (5),
    .KEYCHANGE_PERIOD(3),
    .CNT_W           (32),
    .SEC_W           (SEC_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (en),
    .resync   (resync),
    .clk_fast (clk_fast),
    .tick_fast(tick_fast),
    .clk_key  (clk_key),
    .key_tick (key_tick),
    .sec_tick (sec_tick),
    .secs_left(secs_left)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
  endtask

  // Expected outputs as functions of n and whether the last edge counted.
  task automatic check_all();
    chk("clk_fast", 32'(clk_fast), 32'((n % 4) >= 2));
    chk("clk_key", 32'(clk_key), 32'((n % 60) >= 30));
    chk("tick_fast", 32'(tick_fast), 32'(counted && n > 0 && n % 4 == 0));
    chk("sec_tick", 32'(sec_tick), 32'(counted && n > 0 && n % 20 == 0));
    chk("key_tick", 32'(key_tick), 32'(counted && n > 0 && n % 60 == 0));
    chk("secs_left", 32'(secs_left), 32'(3 - (n % 60) / 20));
  endtask

  task automatic step(input logic r, input logic rs, input logic e);
    sys_rst = r;
    resync  = rs;
    en      = e;
    @(posedge sys_clk);
    #1;
    if (r || rs) begin
      n = 0;
      counted = 0;
    end else if (e) begin
      n++;
      counted = 1;
    end else begin
      counted = 0;
    end
    n_tf += int'(tick_fast);
    n_st += int'(sec_tick);
    n_kt += int'(key_tick);
    check_all();
  endtask

  initial begin
    // Reset state
    step(1, 0, 0);
    step(1, 0, 0);
    chk("rst_secs_left", 32'(secs_left), 32'd3);
    chk("rst_clk_fast", 32'(clk_fast), 32'd0);

    // Free run 130 enabled edges
    n_tf = 0; n_st = 0; n_kt = 0;
    for (int i = 0; i < 130; i++) begin
      step(0, 0, 1);
      chk("secs_nonzero", 32'(secs_left != 0), 32'd1);
      if (n == 4) chk("tf_at4", 32'(tick_fast), 32'd1);
      if (n == 20) chk("secs_at20", 32'(secs_left), 32'd2);
      if (n == 40) chk("secs_at40", 32'(secs_left), 32'd1);
      if (n == 60) chk("kt_at60", 32'(key_tick), 32'd1);
      if (n == 60) chk("secs_at60", 32'(secs_left), 32'd3);
    end
    chk("tf_count", 32'(n_tf), 32'd32);
    chk("st_count", 32'(n_st), 32'd6);
    chk("kt_count", 32'(n_kt), 32'd2);

    // Enable toggling at n=18
    step(1, 0, 0);
    for (int i = 0; i < 18; i++) step(0, 0, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    chk("hold_clk_fast", 32'(clk_fast), 32'd1);
    chk("hold_secs", 32'(secs_left), 32'd3);
    step(0, 0, 1);
    chk("resume_n19_st", 32'(sec_tick), 32'd0);
    step(0, 0, 1);
    chk("resume_st", 32'(sec_tick), 32'd1);
    chk("resume_secs", 32'(secs_left), 32'd2);
    step(0, 0, 0);
    chk("strobe_drop", 32'(sec_tick), 32'd0);

    // Resync at n=45
    step(1, 0, 0);
    for (int i = 0; i < 45; i++) step(0, 0, 1);
    chk("pre_rs_clk_key", 32'(clk_key), 32'd1);
    chk("pre_rs_secs", 32'(secs_left), 32'd1);
    step(0, 1, 1);
    chk("rs_clk_key", 32'(clk_key), 32'd0);
    chk("rs_secs", 32'(secs_left), 32'd3);
    n_kt = 0;
    for (int i = 1; i <= 60; i++) begin
      step(0, 0, 1);
      if (i == 15) chk("no_old_kt", 32'(key_tick), 32'd0);
      if (i == 59) chk("kt_count_59", 32'(n_kt), 32'd0);
    end
    chk("rs_kt_at60", 32'(key_tick), 32'd1);

    // Simultaneous reset and resync, then held resync
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    step(1, 1, 0);
    chk("rr_secs", 32'(secs_left), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1);
      chk("hold_rs_clk_fast", 32'(clk_fast), 32'd0);
      chk("hold_rs_tf", 32'(tick_fast), 32'd0);
    end
    step(0, 0, 1);
    chk("rs_release_n1", 32'(clk_fast), 32'd0);
    step(0, 0, 1);
    chk("rs_release_n2", 32'(clk_fast), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
